cpu_step_controller: RTL and testbench
======================================

# cpu_step_controller

Sequencer for the single-cycle processor datapath (PC, register file, ULA, data memory). It replaces the raw push-button clock with a one-cycle clock-enable pulse, `cpu_step`, that every processor state element qualifies on. Three sources can issue that pulse: single-step (debounced key), free-run at a programmable rate, or neither, with a PC breakpoint that halts free-run. It also keeps a count of executed instructions for the LCD and LED debug outputs.

## Interface
Parameters:
- `PC_W`, 8: width of PC and breakpoint address.
- `CNT_W`, 16: width of the instruction counter.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable samples needed to accept a key level change.
- `RUN_DIV`, 25000000: clk cycles between step pulses in RUN (minimum 2).

Ports:
- `clk`, in, 1: system clock (50 MHz).
- `rst`, in, 1: synchronous, active-high reset.
- `key_n`, in, 1: raw step push-button, active-low, asynchronous.
- `run`, in, 1: free-run request (switch level).
- `brk_en`, in, 1: breakpoint enable.
- `brk_pc`, in, PC_W: breakpoint address.
- `pc`, in, PC_W: current processor PC.
- `cpu_step`, out, 1: one-cycle processor clock enable (registered).
- `state`, out, 2: current FSM state (HALT=0, RUN=1, BRK=2).
- `brk_hit`, out, 1: high while in BRK.
- `instr_cnt`, out, CNT_W: number of `cpu_step` pulses issued; wraps.

## Operation
Reset values:
- `cpu_step` = 0, `state` = HALT, `brk_hit` = 0, `instr_cnt` = 0.
- Run timer = 0.
- Debounced key level = 1 (released); synchronizer flops = 1.

Debounce:
- `key_n` passes through a 2-flop synchronizer.
- The debounced level changes only after the synchronized value has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any agreeing sample clears the counter.
- `press` is a 1-cycle pulse on each 1→0 transition of the debounced level.
- A key held through reset produces exactly one `press` after debounce.

FSM:
- HALT:
  - `press` issues one `cpu_step` and stays in HALT.
  - `run`=1 goes to RUN and clears the run timer.
  - If both occur in the same cycle, `run` wins and there is no step pulse.
- RUN:
  - The run timer counts 0..RUN_DIV-1. At RUN_DIV-1 it wraps to 0 and a pulse is due.
  - Pulse due, `brk_en`=1 and `pc`==`brk_pc`: no pulse; go to BRK.
  - Pulse due otherwise: issue `cpu_step`.
  - `run`=0 in any cycle: go to HALT with no pulse. This takes priority over a due pulse.
  - `press` is ignored.
- BRK:
  - `press` issues one `cpu_step` (steps past the breakpoint) and goes to HALT.
  - `run`=0 goes to HALT with no pulse.
  - If both occur, `press` wins.
  - BRK is left only by one of these two events. Dropping `brk_en` does not leave BRK.
- Encoding 3 is illegal and recovers to HALT on the next edge.

Instruction counter:
- `instr_cnt` increments by 1 in the cycle after each `cpu_step` is asserted.
- Modulo 2^CNT_W; wraps from all-ones to 0.

## Timing
- `cpu_step` is registered and high for exactly one clk cycle per step. It is never high two consecutive cycles.
- Step latency: `cpu_step` rises on the 3+DEBOUNCE_CYCLES-th edge after the first edge that samples `key_n`=0. This breaks down as 2 synchronizer edges, then DEBOUNCE_CYCLES counting edges, then 1 registered output edge.
- RUN cadence: the first pulse comes RUN_DIV edges after the edge entering RUN. After that, one pulse every RUN_DIV cycles.
- Breakpoint compare uses `pc` sampled in the due cycle. The processor PC updates one edge after `cpu_step`, so the compare sees the PC of the next instruction to execute.
- `rst` mid-operation aborts any pending pulse; outputs take reset values on the next edge.

## Structure
- Package `cpu_ctrl_pkg`: state encodings HALT/RUN/BRK, state width 2.
- Sub-module `key_debounce` (synchronizer, stability counter, `press` pulse). It is parameterised by `DEBOUNCE_CYCLES` and reused for other panel keys.
- Top of the processor ties `cpu_step` to the PC and register-file enables in place of the raw key clock.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, RUN_DIV=8, PC_W=8.
- Reset: assert `rst` 2 cycles → `state`=0, `cpu_step`=0, `instr_cnt`=0.
- Single step: in HALT, hold `key_n`=0 for 10 cycles → exactly one `cpu_step` on edge 7; `instr_cnt`=1.
- Bounce: in HALT, toggle `key_n` 0/1 every 2 cycles for 20 cycles → no `cpu_step`.
- Free-run: `run`=1 for 40 cycles with `brk_en`=0 → pulses at edges 8, 16, 24, 32, 40; `instr_cnt`=5.
- Breakpoint: `brk_en`=1, `brk_pc`=8'h03, with a PC model incrementing on each `cpu_step` from 0 → 3 pulses, then `state`=BRK, `brk_hit`=1. Then a key press → one pulse, `state`=HALT.
- Priority and wrap:
  - In RUN, drop `run` on the due cycle → no pulse, HALT.
  - Preload counter to 16'hFFFF and step once → `instr_cnt`=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// ============================================================================
// Module      : cpu_ctrl_pkg
// Description : Shared state encodings for the processor step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_BRK  = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Synchronises and debounces an active-low key; one-cycle press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_press;
    logic               w_accept;

    // The level flips on the last counting edge, so press can be registered
    // alongside it without adding a cycle of latency.
    assign w_accept = (r_sync2 != r_level) &&
                      (r_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= key_n;
            r_sync2 <= r_sync1;
            r_press <= w_accept && r_level;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/cpu_step.sv
// ============================================================================
// Module      : cpu_step_controller
// Description : Issues the processor clock-enable from key, free-run or break.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_step_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int PC_W            = 8,
    parameter int CNT_W           = 16,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_n,
    input  logic               run,
    input  logic               brk_en,
    input  logic [PC_W-1:0]    brk_pc,
    input  logic [PC_W-1:0]    pc,
    output logic               cpu_step,
    output logic [STATE_W-1:0] state,
    output logic               brk_hit,
    output logic [CNT_W-1:0]   instr_cnt
);

    localparam int c_timer_w = $clog2(RUN_DIV);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_timer_w-1:0] r_timer;
    logic [c_timer_w-1:0] w_timer_next;
    logic                 r_step;
    logic                 w_step_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_press;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .press (w_press)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HALT;
            r_timer <= '0;
            r_step  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
            r_step  <= w_step_next;
            if (r_step) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_timer_next = r_timer;
        w_step_next  = 1'b0;
        case (r_state)
            ST_HALT: begin
                if (run) begin
                    w_state_next = ST_RUN;
                    w_timer_next = '0;
                end else if (w_press) begin
                    w_step_next = 1'b1;
                end
            end
            ST_RUN: begin
                // Leaving RUN outranks a due pulse so the switch stops cleanly.
                if (!run) begin
                    w_state_next = ST_HALT;
                end else if (r_timer == c_timer_w'(RUN_DIV - 1)) begin
                    w_timer_next = '0;
                    if (brk_en && (pc == brk_pc)) begin
                        w_state_next = ST_BRK;
                    end else begin
                        w_step_next = 1'b1;
                    end
                end else begin
                    w_timer_next = r_timer + c_timer_w'(1);
                end
            end
            ST_BRK: begin
                if (w_press) begin
                    w_step_next  = 1'b1;
                    w_state_next = ST_HALT;
                end else if (!run) begin
                    w_state_next = ST_HALT;
                end
            end
            default: begin
                w_state_next = ST_HALT;
            end
        endcase
    end

    assign cpu_step  = r_step;
    assign state     = r_state;
    assign brk_hit   = (r_state == ST_BRK);
    assign instr_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
// ============================================================================
// Module      : tb_cpu_step_controller
// Description : Directed self-checking bench for the processor step sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_step_controller;

    localparam int PC_W = 8;
    localparam int CNT_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            key_n;
    logic            run;
    logic            brk_en;
    logic [PC_W-1:0] brk_pc;
    logic [PC_W-1:0] pc;
    logic            pc_clr;
    logic            cpu_step;
    logic [1:0]      state;
    logic            brk_hit;
    logic [CNT_W-1:0] instr_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int p;
    int f;

    cpu_step_controller #(
        .PC_W            (PC_W),
        .CNT_W           (CNT_W),
        .DEBOUNCE_CYCLES (4),
        .RUN_DIV         (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .run       (run),
        .brk_en    (brk_en),
        .brk_pc    (brk_pc),
        .pc        (pc),
        .cpu_step  (cpu_step),
        .state     (state),
        .brk_hit   (brk_hit),
        .instr_cnt (instr_cnt)
    );

    always #5 clk = ~clk;

    // Processor PC: advances on the edge after each step pulse.
    always_ff @(posedge clk) begin
        if (rst || pc_clr) begin
            pc <= '0;
        end else if (cpu_step) begin
            pc <= pc + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts step pulses over n edges and records the edge of the first one.
    task automatic cycles(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (cpu_step) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
    endtask

    initial begin
        rst = 1'b1; key_n = 1'b1; run = 1'b0; brk_en = 1'b0;
        brk_pc = 8'h00; pc_clr = 1'b0;
        tick(); tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_step", 32'(cpu_step), 32'd0);
        check("rst_cnt", 32'(instr_cnt), 32'd0);
        check("rst_brk_hit", 32'(brk_hit), 32'd0);
        rst = 1'b0;

        // Single step
        key_n = 1'b0;
        cycles(10, p, f);
        check("step_pulses", 32'(p), 32'd1);
        check("step_edge", 32'(f), 32'd7);
        check("step_cnt", 32'(instr_cnt), 32'd1);
        key_n = 1'b1;
        cycles(10, p, f);
        check("release_pulses", 32'(p), 32'd0);

        // Bounce
        for (int i = 0; i < 10; i++) begin
            key_n = i[0];
            tick(); if (cpu_step) p++;
            tick(); if (cpu_step) p++;
        end
        key_n = 1'b1;
        cycles(10, f, f);
        check("bounce_pulses", 32'(p + f), 32'd0);
        check("bounce_cnt", 32'(instr_cnt), 32'd1);

        // Free-run
        run = 1'b1;
        tick();
        check("run_enter", 32'(state), 32'd1);
        cycles(40, p, f);
        check("run_pulses", 32'(p), 32'd5);
        check("run_first", 32'(f), 32'd8);
        run = 1'b0;
        tick();
        check("run_exit_state", 32'(state), 32'd0);
        check("run_cnt", 32'(instr_cnt), 32'd6);

        // Breakpoint
        pc_clr = 1'b1; tick(); pc_clr = 1'b0;
        brk_en = 1'b1; brk_pc = 8'h03; run = 1'b1;
        tick();
        cycles(40, p, f);
        check("brk_pulses", 32'(p), 32'd3);
        check("brk_state", 32'(state), 32'd2);
        check("brk_hit", 32'(brk_hit), 32'd1);
        check("brk_cnt", 32'(instr_cnt), 32'd9);
        brk_en = 1'b0;
        cycles(5, p, f);
        check("brk_sticky_pulses", 32'(p), 32'd0);
        check("brk_sticky_state", 32'(state), 32'd2);
        key_n = 1'b0;
        cycles(6, p, f);
        check("brk_press_early", 32'(p), 32'd0);
        tick();
        check("brk_press_step", 32'(cpu_step), 32'd1);
        check("brk_press_state", 32'(state), 32'd0);
        run = 1'b0;
        tick();
        check("brk_after_step", 32'(cpu_step), 32'd0);
        check("brk_after_state", 32'(state), 32'd0);
        check("brk_after_hit", 32'(brk_hit), 32'd0);
        check("brk_after_cnt", 32'(instr_cnt), 32'd10);
        key_n = 1'b1;
        cycles(10, p, f);

        // Dropping run on the due cycle
        run = 1'b1;
        tick();
        cycles(7, p, f);
        check("due_pre_pulses", 32'(p), 32'd0);
        run = 1'b0;
        tick();
        check("due_drop_step", 32'(cpu_step), 32'd0);
        check("due_drop_state", 32'(state), 32'd0);
        cycles(5, p, f);
        check("due_drop_cnt", 32'(instr_cnt + CNT_W'(p)), 32'd10);

        // Press and run together in HALT
        key_n = 1'b0;
        cycles(6, p, f);
        run = 1'b1;
        tick();
        check("press_run_step", 32'(cpu_step), 32'd0);
        check("press_run_state", 32'(state), 32'd1);
        run = 1'b0;
        tick();
        key_n = 1'b1;
        cycles(10, p, f);
        check("press_run_cnt", 32'(instr_cnt), 32'd10);

        // Counter wrap
        run = 1'b1;
        tick();
        cycles(1960, p, f);
        check("wrap_pulses", 32'(p), 32'd245);
        run = 1'b0;
        tick();
        check("wrap_full", 32'(instr_cnt), 32'd255);
        key_n = 1'b0;
        cycles(10, p, f);
        check("wrap_step", 32'(p), 32'd1);
        check("wrap_zero", 32'(instr_cnt), 32'd0);
        key_n = 1'b1;
        cycles(10, p, f);

        // Reset aborts a due pulse
        run = 1'b1;
        tick();
        cycles(7, p, f);
        rst = 1'b1;
        tick();
        check("midrst_step", 32'(cpu_step), 32'd0);
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_cnt", 32'(instr_cnt), 32'd0);
        rst = 1'b0; run = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
